// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment driver: prescaled digit scan, frame-synchronous
// value commit, leading-zero suppression, per-digit DP, blanking and polarity select.
module hex_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    blank,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oAN,
    output logic                    pending
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF     = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            4'hF: hex_glyph = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_stage;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic                    w_frame_tick;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [3:0]              w_nib;
    logic                    w_sel_dp;
    logic                    w_sel_blank;
    logic                    w_on;
    logic [6:0]              w_seg_act;
    logic                    w_dp_act;
    logic [NUM_DIGITS-1:0]   w_an_act;

    assign w_tick       = en && (r_presc == PRESC_LAST);
    assign w_frame_tick = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else if (en) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // NOTE: non-blocking assignments let a commit and a new load share one edge:
    // the display takes the staging value from before this edge's load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage    <= '0;
            r_stage_dp <= '0;
            r_disp     <= '0;
            r_disp_dp  <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_frame_tick && r_pending) begin
                r_disp    <= r_stage;
                r_disp_dp <= r_stage_dp;
            end
            if (load) begin
                r_stage    <= value;
                r_stage_dp <= dp_in;
                r_pending  <= 1'b1;
            end else if (w_frame_tick) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic w_zero_run;
        w_zero_run = 1'b1;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_disp[4*i +: 4] == 4'h0);
            if (LZ_SUPPRESS && i > 0) w_lz_blank[i] = w_zero_run;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        w_nib       = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_disp[4*i +: 4];
                w_sel_dp    = r_disp_dp[i];
                w_sel_blank = w_lz_blank[i];
            end
        end
    end

    assign w_on      = !blank && !w_sel_blank;
    assign w_seg_act = w_on ? hex_glyph(w_nib) : 7'h00;
    assign w_dp_act  = w_on && w_sel_dp;
    assign w_an_act  = w_on ? (NUM_DIGITS'(1) << r_idx) : '0;

    // Outputs are computed active-high, then flipped by XOR with the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_act ^ SEG_OFF;
            r_dp  <= w_dp_act ^ DP_OFF;
            r_an  <= w_an_act ^ AN_OFF;
        end
    end

    assign oSEG    = r_seg;
    assign oDP     = r_dp;
    assign oAN     = r_an;
    assign pending = r_pending;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: an active-low/LZ instance and an
// active-high/no-LZ instance share stimulus; expected outputs go through a queue.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        rst, en, blank, load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0]  seg_l, seg_h;
    logic        dp_l, dp_h, pend_l, pend_h;
    logic [3:0]  an_l, an_h;

    hex_display_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .blank(blank), .load(load),
        .value(value), .dp_in(dp_in),
        .oSEG(seg_l), .oDP(dp_l), .oAN(an_l), .pending(pend_l)
    );

    hex_display_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1'b0)
    ) dut_ah (
        .clk(clk), .rst(rst), .en(en), .blank(blank), .load(load),
        .value(value), .dp_in(dp_in),
        .oSEG(seg_h), .oDP(dp_h), .oAN(an_h), .pending(pend_h)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         ah;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Bench-side scan position: prescaler, index, and the index the outputs show.
    int   m_presc = 0;
    int   m_idx   = 0;
    int   m_out_idx = 0;
    bit   m_frame = 1'b0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            m_frame = 1'b0;
            if (rst) begin
                m_presc = 0;
                m_idx   = 0;
            end else begin
                m_out_idx = m_idx;
                if (en) begin
                    if (m_presc == 3) begin
                        m_presc = 0;
                        m_frame = (m_idx == 3);
                        m_idx   = (m_idx + 1) % 4;
                    end else begin
                        m_presc = m_presc + 1;
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input int idx, input int presc, input string tag);
        int n = 0;
        while (!(m_idx == idx && m_presc == presc) && n < 64) begin
            cyc(1);
            n++;
        end
        if (n >= 64) begin
            $display("FAIL %s: scan position idx=%0d presc=%0d not reached", tag, idx, presc);
            $fatal(1);
        end
    endtask

    task automatic next_frame(input string tag);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (!m_frame && n < 64);
        if (!m_frame) begin
            $display("FAIL %s: frame boundary not reached", tag);
            $fatal(1);
        end
    endtask

    task automatic push(input string tag, input bit ah, input logic [3:0] an,
                        input logic [6:0] seg, input logic dp);
        exp_t e;
        e.tag = tag;
        e.ah  = ah;
        e.an  = an;
        e.seg = seg;
        e.dp  = dp;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [11:0] obs, want;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_miss++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (sb.size() == 0) return;
        e    = sb.pop_front();
        obs  = e.ah ? {an_h, seg_h, dp_h} : {an_l, seg_l, dp_l};
        want = {e.an, e.seg, e.dp};
        assert (obs === want) else begin
            n_miss++;
            $error("FAIL %s: observed an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                   e.tag, obs[11:8], obs[7:1], obs[0], want[11:8], want[7:1], want[0]);
        end
    endtask

    task automatic expect_now(input string tag, input bit ah, input logic [3:0] an,
                              input logic [6:0] seg, input logic dp);
        push(tag, ah, an, seg, dp);
        pop_check();
    endtask

    task automatic check_pend(input string tag, input logic exp_p);
        n_vec++;
        assert (pend_l === exp_p && pend_h === exp_p) else begin
            n_miss++;
            $error("FAIL %s: observed pending=%b/%b, expected %b", tag, pend_l, pend_h, exp_p);
        end
    endtask

    // Starts at a frame boundary; checks each slot on its first cycle and on the
    // cycle after the index moves on (still the old slot, one cycle of latency).
    task automatic check_frame(input string tag, input logic [15:0] an4,
                               input logic [27:0] seg4, input logic [3:0] dp4);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("%s_s%0d_first", tag, k), 1'b0, an4[4*k +: 4], seg4[7*k +: 7], dp4[k]);
            push($sformatf("%s_s%0d_last", tag, k), 1'b0, an4[4*k +: 4], seg4[7*k +: 7], dp4[k]);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            pop_check();
            cyc(3);
            pop_check();
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        cyc(1);
        load  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; blank = 1'b0; load = 1'b0;
        value = 16'h0000; dp_in = 4'h0;

        // Reset state
        cyc(3);
        expect_now("reset_al", 1'b0, 4'hF, 7'h7F, 1'b1);
        expect_now("reset_ah", 1'b1, 4'h0, 7'h00, 1'b0);
        check_pend("reset_pend", 1'b0);
        rst = 1'b0;
        cyc(1);
        expect_now("release_al", 1'b0, 4'hE, 7'h40, 1'b1);
        expect_now("release_ah", 1'b1, 4'h1, 7'h3F, 1'b0);

        // Scan order with DP on digit 1
        do_load(16'h1234, 4'b0010);
        check_pend("scan_staged", 1'b1);
        next_frame("scan_commit");
        check_pend("scan_committed", 1'b0);
        check_frame("scan_1234", {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101);

        // Leading-zero suppression
        do_load(16'h00A5, 4'b1000);
        next_frame("lz_commit");
        check_frame("lz_00a5", {4'hF, 4'hF, 4'hD, 4'hE},
                    {7'h7F, 7'h7F, 7'h08, 7'h12}, 4'b1111);
        do_load(16'h0000, 4'b0000);
        next_frame("lz0_commit");
        check_frame("lz_0000", {4'hF, 4'hF, 4'hF, 4'hE},
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);

        // Tear-free update: load mid-frame, old value holds until the frame ends
        wait_state(1, 1, "tear_load");
        do_load(16'hBEEF, 4'b0000);
        check_pend("tear_pending", 1'b1);
        wait_state(2, 2, "tear_old");
        expect_now("tear_old_slot2", 1'b0, 4'hF, 7'h7F, 1'b1);
        next_frame("tear_commit");
        check_pend("tear_committed", 1'b0);
        check_frame("tear_beef", {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

        // Second load before commit wins
        wait_state(1, 1, "over_load1");
        do_load(16'hBEEF, 4'b0000);
        wait_state(2, 2, "over_load2");
        do_load(16'hCAFE, 4'b0000);
        wait_state(3, 2, "over_old");
        expect_now("over_old_slot3", 1'b0, 4'h7, 7'h03, 1'b1);
        check_pend("over_pending", 1'b1);
        next_frame("over_commit");
        check_frame("over_cafe", {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h46, 7'h08, 7'h0E, 7'h06}, 4'b1111);

        // Load coincident with the frame tick while a value is pending
        wait_state(1, 1, "sim_load1");
        do_load(16'h1111, 4'b0000);
        check_pend("sim_pending1", 1'b1);
        wait_state(3, 3, "sim_edge");
        do_load(16'h5555, 4'b0000);
        check_pend("sim_pending_kept", 1'b1);
        check_frame("sim_1111", {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111);
        check_pend("sim_pending_cleared", 1'b0);
        check_frame("sim_5555", {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1111);

        // en=0 freezes the scan
        wait_state(1, 2, "freeze_start");
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            expect_now($sformatf("freeze_c%0d", i), 1'b0, 4'hD, 7'h12, 1'b1);
        end
        en = 1'b1;

        // Blanking: outputs off, scan and commit keep running
        blank = 1'b1;
        cyc(1);
        expect_now("blank_al", 1'b0, 4'hF, 7'h7F, 1'b1);
        expect_now("blank_ah", 1'b1, 4'h0, 7'h00, 1'b0);
        do_load(16'h0008, 4'b0000);
        check_pend("blank_pending", 1'b1);
        next_frame("blank_commit");
        check_pend("blank_committed", 1'b0);
        cyc(1);
        expect_now("blank_after_commit_al", 1'b0, 4'hF, 7'h7F, 1'b1);
        expect_now("blank_after_commit_ah", 1'b1, 4'h0, 7'h00, 1'b0);
        blank = 1'b0;
        cyc(1);
        expect_now("unblank_al_s0", 1'b0, 4'hE, 7'h00, 1'b1);
        expect_now("polarity_ah_s0", 1'b1, 4'h1, 7'h7F, 1'b0);
        wait_state(1, 2, "polarity_s1");
        expect_now("unblank_al_s1", 1'b0, 4'hF, 7'h7F, 1'b1);
        expect_now("polarity_ah_s1", 1'b1, 4'h2, 7'h3F, 1'b0);

        // Reset mid-scan discards staged and displayed values
        do_load(16'h1234, 4'b1111);
        check_pend("rst_pending_before", 1'b1);
        rst = 1'b1;
        cyc(1);
        expect_now("midrst_al", 1'b0, 4'hF, 7'h7F, 1'b1);
        expect_now("midrst_ah", 1'b1, 4'h0, 7'h00, 1'b0);
        check_pend("midrst_pend", 1'b0);
        rst = 1'b0;
        cyc(1);
        expect_now("midrst_release_al", 1'b0, 4'hE, 7'h40, 1'b1);
        expect_now("midrst_release_ah", 1'b1, 4'h1, 7'h3F, 1'b0);
        next_frame("midrst_frame");
        cyc(1);
        expect_now("midrst_no_commit", 1'b0, 4'hE, 7'h40, 1'b1);
        check_pend("midrst_pend_frame", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Parametrised, time-multiplexed multi-digit hexadecimal 7-segment display driver.
- Holds a NUM_DIGITS-nibble display value and scans the digits one at a time with a refresh prescaler.
- Adds frame-synchronous (tear-free) value update, leading-zero suppression, per-digit decimal points, global blanking and selectable output polarity.
- Sits between core debug/status registers and board seven-segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>=2).
- ACTIVE_LOW, 1, 1: segment, DP and anode outputs active-low; 0: active-high.
- LZ_SUPPRESS, 1, 1: blank leading zero digits; 0: show all digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  prescaler enable; 0 freezes the scan
- blank  in  1  1 forces all digits off
- load  in  1  one-cycle strobe; captures value and dp_in
- value  in  4*NUM_DIGITS  hex value; digit i = value[4i+3:4i]
- dp_in  in  NUM_DIGITS  decimal point per digit
- oSEG  out  7  segments in gfedcba order (bit6=g)
- oDP  out  1  decimal point of the active digit
- oAN  out  NUM_DIGITS  digit enables, one-hot (ACTIVE_LOW=1: one-cold)
- pending  out  1  staged value not yet committed to the display

Behaviour:
- Reset:
  - prescaler=0, digit index=0, staging and display registers=0, pending=0.
  - All outputs in their inactive level: oSEG all off, oDP off, oAN all off (7'h7F / 1 / all-ones when ACTIVE_LOW=1; all zeros when ACTIVE_LOW=0).
  - Reset overrides load and any in-progress scan.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while en=1 and holds while en=0.
  - tick = (count==REFRESH_DIV-1) && en.
  - On tick, the prescaler returns to 0 and the index advances; it wraps NUM_DIGITS-1 -> 0.
  - frame_tick = tick && index==NUM_DIGITS-1.
- Load / commit:
  - load=1 writes staging<=value and staging_dp<=dp_in, and sets pending=1. A second load before commit overwrites staging.
  - On frame_tick with pending=1: display<=staging. pending clears unless load is also high that cycle; in that case the new value goes to staging and pending stays 1 (committed next frame).
  - The display never changes mid-frame.
- Decode:
  - Active-high glyphs 0..F = 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - Inverted when ACTIVE_LOW=1.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit i is blank when i>0 and all display nibbles i..NUM_DIGITS-1 are zero.
  - Digit 0 is always shown.
  - A blanked digit has oAN inactive, so its DP is also off.
- Output registration:
  - oSEG, oDP and oAN are registered and reflect the index and display state of the previous cycle (1-cycle latency after an index change).
  - blank=1 drives all oAN, oSEG and oDP inactive from the next cycle. The scan keeps running and pending/commit still operate.
- NUM_DIGITS=1: index stays 0 and every tick is a frame_tick.

Test Plan:
- Reset: hold rst 3 cycles with ACTIVE_LOW=1 -> oAN=4'hF, oSEG=7'h7F, oDP=1, pending=0. Release with value=0 -> first scan slot shows digit0 glyph 7'h40 with oAN=4'hE.
- Scan order: REFRESH_DIV=4, NUM_DIGITS=4, load value=16'h1234 -> after commit, oAN cycles E,D,B,7 every 4 cycles. oSEG tracks digit 4,3,2,1 = 66,4F,5B,06 (inverted), each 1 cycle after the index change.
- LZ suppression: load 16'h00A5, dp_in=4'b1000 -> slots 3 and 2 have oAN=F and DP off; slot 1 shows A (~77), slot 0 shows 5 (~6D). Repeat with 16'h0000 -> only digit0 lit, glyph 0.
- Tear-free update: load 16'hBEEF mid-frame (index=1) -> pending=1; the old value shows until frame_tick, then BEEF from index 0 and pending=0. Second load 16'hCAFE before frame_tick -> CAFE is committed, not BEEF.
- Simultaneous: load 16'h5555 coincident with frame_tick while pending holds 16'h1111 -> 1111 is displayed, pending stays 1, and 5555 appears the following frame.
- Disturbances: en=0 mid-slot freezes oAN for 20 cycles. blank=1 -> all outputs off next cycle while index still advances. rst mid-scan -> reset values next cycle and the display register is cleared.
- Polarity: ACTIVE_LOW=0, value 8 -> oSEG=7'h7F and oAN one-hot.
